qp_channel_arbiter: RTL and testbench
=====================================

Name: qp_channel_arbiter

Overview:
- Shares one Q/P-channel slave among N requesters; one transaction is outstanding at a time.
- Q channel carries the request. The slave returns a one-cycle QREADY pulse, then some cycles later a one-cycle PVALID pulse with response data.
- Round-robin grant, registered request payload, response routed back to the granted requester.
- A response timeout guards against a hung slave.

Parameters:
N, 4, number of upstream requesters (2..16)
QW, 32, Q-channel payload width
PW, 32, P-channel payload width
TIMEOUT, 64, max cycles in RESP waiting for DN_PVALID; 0 disables timeout

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous reset, active-high
UP_QVALID  in  N  per-requester request valid; held until its UP_QREADY
UP_QDATA  in  N*QW  request payloads, requester i at [i*QW +: QW]
UP_QREADY  out  N  one-cycle accept pulse to granted requester
UP_PVALID  out  N  one-cycle response pulse to granted requester
UP_PDATA  out  PW  response payload, shared, valid with any UP_PVALID bit
UP_PERR  out  1  high with UP_PVALID when the response is a timeout
DN_QVALID  out  1  request valid to slave
DN_QDATA  out  QW  request payload to slave
DN_QREADY  in  1  slave accept pulse
DN_PVALID  in  1  slave response pulse
DN_PDATA  in  PW  slave response payload
BUSY  out  1  high whenever state != IDLE
STRAY  out  1  one-cycle pulse when DN_PVALID arrives outside RESP

Behaviour:
- States:
  - IDLE: no transaction open.
  - REQ: request driven to the slave, waiting for DN_QREADY.
  - RESP: waiting for DN_PVALID or timeout.
- Reset (RST=1 at a clock edge, any state):
  - State→IDLE, priority pointer→0 (requester 0 highest), timeout counter→0.
  - Grant index→0; DN_QDATA register→0.
  - DN_QVALID=0, UP_QREADY=0, UP_PVALID=0, UP_PERR=0, UP_PDATA=0, BUSY=0, STRAY=0.
  - Any open transaction is abandoned with no response pulse.
- IDLE:
  - If any UP_QVALID bit is set, pick the first set bit searching from the pointer upward with wrap-around.
  - Register the grant index and that requester's UP_QDATA into DN_QDATA; go to REQ.
  - Grant decision to DN_QVALID high is 1 cycle.
- REQ:
  - DN_QVALID=1 from a register; DN_QDATA holds the captured payload, so UP_QDATA changes have no effect.
  - UP_QREADY[grant]=DN_QREADY combinationally (zero added latency); all other UP_QREADY bits stay 0.
  - On DN_QREADY=1: next state RESP, DN_QVALID drops the next cycle, timeout counter clears.
  - Upstream dropping UP_QVALID during REQ is ignored; the request still completes.
- RESP:
  - DN_QVALID=0. The counter increments each cycle.
  - On DN_PVALID=1: UP_PVALID[grant]=1, UP_PDATA=DN_PDATA, UP_PERR=0, all combinational, same cycle.
    - Next state IDLE; pointer←(grant+1) mod N.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without DN_PVALID: next cycle drives UP_PVALID[grant]=1, UP_PERR=1, UP_PDATA=0.
    - Then IDLE; pointer advances as above.
  - DN_PVALID arriving on the exact timeout cycle counts as a normal response; no error.
- STRAY:
  - Pulses for one cycle when DN_PVALID=1 in IDLE or REQ.
  - The response data is discarded and state is unchanged.
- DN_QREADY in IDLE or RESP is ignored.
- Back-to-back:
  - A response cycle's UP_PVALID and the next IDLE grant are distinct cycles.
  - Minimum transaction is 3 cycles: IDLE grant, REQ with immediate DN_QREADY, RESP with immediate DN_PVALID.
- Fairness: a requester holding UP_QVALID is granted within N transactions.
- UP_PVALID and UP_QREADY are at most one-hot.

Test Plan:
- Single requester 2, UP_QDATA=0xA5A5_0001, slave QREADY after 5 cycles and PVALID after 3 more, DN_PDATA=0x1234 → DN_QDATA=0xA5A5_0001; UP_QREADY[2] pulses once; UP_PVALID[2] pulses with UP_PDATA=0x1234, UP_PERR=0.
- All 4 requesters held high continuously, 8 transactions → grant order 0,1,2,3,0,1,2,3; never two outstanding; BUSY low exactly one cycle between transactions.
- TIMEOUT=64, slave never asserts PVALID → UP_PVALID[grant] with UP_PERR=1 exactly 64 cycles after entering RESP. A later DN_PVALID produces a STRAY pulse and no UP_PVALID.
- RST asserted in RESP → all outputs 0 the next cycle, no response pulse. After release, requesters 3 and 0 both request → requester 0 granted first.
- DN_PVALID injected while in REQ → STRAY=1 for one cycle; transaction continues and completes normally.
- Upstream changes UP_QDATA and drops UP_QVALID during REQ → DN_QDATA stays at the captured value; transaction completes with UP_PVALID to the original requester.

Source files
------------

// File: rtl/qp_channel_arbiter.sv
// qp_channel_arbiter: round-robin sharing of one Q/P-channel slave among N requesters
module qp_channel_arbiter #(
  parameter int N = 4,
  parameter int QW = 32,
  parameter int PW = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    UP_QVALID,
  input  logic [N*QW-1:0] UP_QDATA,
  output logic [N-1:0]    UP_QREADY,
  output logic [N-1:0]    UP_PVALID,
  output logic [PW-1:0]   UP_PDATA,
  output logic            UP_PERR,
  output logic            DN_QVALID,
  output logic [QW-1:0]   DN_QDATA,
  input  logic            DN_QREADY,
  input  logic            DN_PVALID,
  input  logic [PW-1:0]   DN_PDATA,
  output logic            BUSY,
  output logic            STRAY
);
  localparam int GW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO = CW'(TIMEOUT);
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_n;
  logic [GW-1:0] ptr, grant, sel;
  logic [CW-1:0] cnt;
  logic [QW-1:0] q_data;
  logic q_valid, tmo, done;
  assign tmo = (TIMEOUT != 0) && (cnt == TO);
  assign done = (state == RESP) && (DN_PVALID || tmo);
  // first requesting index at or above the pointer, wrapping; lowest offset wins
  always_comb begin
    sel = ptr;
    for (int i = N - 1; i >= 0; i--)
      if (UP_QVALID[(int'(ptr) + i) % N]) sel = GW'((int'(ptr) + i) % N);
  end
  // next state: grant from IDLE, accept in REQ, response or timeout in RESP
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (|UP_QVALID ? REQ : IDLE) :
              (state == REQ)  ? (DN_QREADY ? RESP : REQ) :
              (done ? IDLE : RESP);
  end
  // state, captured grant/payload, response counter and priority pointer
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      grant <= '0;
      cnt <= '0;
      q_data <= '0;
      q_valid <= 1'b0;
    end else begin
      state <= state_n;
      q_valid <= state_n == REQ;
      cnt <= (state == RESP) ? cnt + 1'b1 : '0;
      if (state == IDLE && |UP_QVALID) begin
        grant <= sel;
        q_data <= UP_QDATA[sel*QW +: QW];
      end
      if (done) ptr <= (grant == GW'(N - 1)) ? '0 : grant + 1'b1;
    end
  end
  assign DN_QVALID = q_valid;
  assign DN_QDATA = q_data;
  assign UP_QREADY = (state == REQ && DN_QREADY) ? ONE << grant : '0;
  assign UP_PVALID = done ? ONE << grant : '0;
  assign UP_PERR = done && !DN_PVALID;
  assign UP_PDATA = (state == RESP && DN_PVALID) ? DN_PDATA : '0;
  assign BUSY = state != IDLE;
  assign STRAY = DN_PVALID && state != RESP;
endmodule

// File: tb/tb_qp_channel_arbiter.sv
// tb_qp_channel_arbiter: table-driven transactions plus scoreboard of upstream responses
module tb_qp_channel_arbiter;
  localparam int N = 4, QW = 32, PW = 32, TIMEOUT = 64;
  logic CLK = 1'b0, RST = 1'b1;
  logic [N-1:0] UP_QVALID = '0, UP_QREADY, UP_PVALID;
  logic [N*QW-1:0] UP_QDATA;
  logic [PW-1:0] UP_PDATA, DN_PDATA = '0;
  logic UP_PERR, DN_QVALID, DN_QREADY = 1'b0, DN_PVALID = 1'b0, BUSY, STRAY;
  logic [QW-1:0] DN_QDATA;
  qp_channel_arbiter #(.N(N), .QW(QW), .PW(PW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .UP_QVALID(UP_QVALID), .UP_QDATA(UP_QDATA),
    .UP_QREADY(UP_QREADY), .UP_PVALID(UP_PVALID), .UP_PDATA(UP_PDATA), .UP_PERR(UP_PERR),
    .DN_QVALID(DN_QVALID), .DN_QDATA(DN_QDATA), .DN_QREADY(DN_QREADY), .DN_PVALID(DN_PVALID),
    .DN_PDATA(DN_PDATA), .BUSY(BUSY), .STRAY(STRAY)
  );
  always #5 CLK = ~CLK;
  typedef struct { logic [3:0] mask; int qd; int pd; logic [31:0] pdata; int g; bit inj; bit chg; } vec_t;
  typedef struct { logic [3:0] pv; logic [31:0] pd; logic perr; } resp_t;
  resp_t sbq[$];
  vec_t tv[$];
  logic [31:0] pay [4] = '{32'hAAAA_0000, 32'hBBBB_0001, 32'hA5A5_0001, 32'hDDDD_0003};
  int n_vec = 0, n_err = 0;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic look();
    resp_t e;
    @(negedge CLK);
    if (UP_PVALID != '0) begin
      if (sbq.size() == 0) check("unexpected_pvalid", UP_PVALID, 0);
      else begin
        e = sbq.pop_front();
        check("pvalid", UP_PVALID, e.pv);
        check("pdata", UP_PDATA, e.pd);
        check("perr", UP_PERR, e.perr);
      end
    end
  endtask
  task automatic txn(input vec_t v);
    resp_t e;
    UP_QVALID = v.mask;
    look();
    check("idle_busy", BUSY, 0);
    step();
    for (int i = 0; i <= v.qd; i++) begin
      DN_QREADY = (i == v.qd);
      DN_PVALID = v.inj && i == 0;
      DN_PDATA = 32'hDEAD_BEEF;
      look();
      if (i == 0) begin
        check("req_qvalid", DN_QVALID, 1);
        check("req_busy", BUSY, 1);
        check("req_qdata", DN_QDATA, pay[v.g]);
      end
      if (v.inj) check("stray_req", STRAY, i == 0);
      if (i == v.qd) begin
        check("qready", UP_QREADY, 4'b1 << v.g);
        check("hold_qdata", DN_QDATA, pay[v.g]);
      end
      if (v.chg && i == 0) begin
        UP_QDATA = ~UP_QDATA;
        UP_QVALID = '0;
      end
      step();
    end
    DN_QREADY = 1'b0;
    for (int i = 0; i <= v.pd; i++) begin
      DN_PVALID = (i == v.pd);
      DN_PDATA = v.pdata;
      if (i == v.pd) begin
        e.pv = 4'b1 << v.g;
        e.pd = v.pdata;
        e.perr = 1'b0;
        sbq.push_back(e);
      end
      look();
      if (i == 0) check("resp_qvalid", DN_QVALID, 0);
      if (i == v.pd) check("stray_resp", STRAY, 0);
      step();
    end
    DN_PVALID = 1'b0;
    if (v.chg) UP_QDATA = ~UP_QDATA;
  endtask
  initial begin
    resp_t e;
    UP_QDATA = {pay[3], pay[2], pay[1], pay[0]};
    for (int i = 0; i < 8; i++) tv.push_back('{4'hF, i % 3, (i * 2) % 5, 32'h1000 + i, i % 4, 1'b0, 1'b0});
    tv.push_back('{4'b0100, 5, 3, 32'h1234, 2, 1'b0, 1'b0});
    tv.push_back('{4'b1001, 1, 1, 32'h2222, 3, 1'b1, 1'b0});
    tv.push_back('{4'b1001, 2, 2, 32'h3333, 0, 1'b0, 1'b1});
    tv.push_back('{4'b0011, 1, 0, 32'h4444, 1, 1'b0, 1'b0});
    tv.push_back('{4'b0011, 0, 4, 32'h5555, 0, 1'b0, 1'b0});
    tv.push_back('{4'b1000, 0, 0, 32'h6666, 3, 1'b0, 1'b0});
    step();
    step();
    look();
    check("rst_outs", {DN_QVALID, UP_QREADY, UP_PVALID, UP_PERR, UP_PDATA, BUSY, STRAY}, 0);
    check("rst_qdata", DN_QDATA, 0);
    RST = 1'b0;
    step();
    foreach (tv[i]) txn(tv[i]);
    UP_QVALID = 4'b0010;
    look();
    step();
    DN_QREADY = 1'b1;
    look();
    check("to_qready", UP_QREADY, 4'b0010);
    step();
    DN_QREADY = 1'b0;
    UP_QVALID = '0;
    for (int k = 0; k <= TIMEOUT; k++) begin
      if (k == TIMEOUT) begin
        e.pv = 4'b0010;
        e.pd = '0;
        e.perr = 1'b1;
        sbq.push_back(e);
      end
      look();
      if (k == TIMEOUT) check("to_busy", BUSY, 1);
      step();
    end
    DN_PVALID = 1'b1;
    DN_PDATA = 32'hCAFE;
    look();
    check("late_stray", STRAY, 1);
    check("late_pvalid", UP_PVALID, 0);
    step();
    DN_PVALID = 1'b0;
    look();
    check("stray_one", STRAY, 0);
    step();
    UP_QVALID = 4'b0100;
    look();
    step();
    DN_QREADY = 1'b1;
    look();
    check("rst_qready", UP_QREADY, 4'b0100);
    step();
    DN_QREADY = 1'b0;
    UP_QVALID = '0;
    look();
    check("rst_in_resp", BUSY, 1);
    step();
    RST = 1'b1;
    look();
    step();
    RST = 1'b0;
    look();
    check("rst_resp_outs", {DN_QVALID, UP_QREADY, UP_PVALID, UP_PERR, UP_PDATA, BUSY, STRAY}, 0);
    check("rst_resp_qdata", DN_QDATA, 0);
    step();
    txn('{4'b1001, 1, 2, 32'h600D, 0, 1'b0, 1'b0});
    UP_QVALID = '0;
    look();
    step();
    check("sb_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
